// File: rtl/tracker_pkg.sv
// Shared types and constants for the multi-target colour tracker.
// Colour and count widths are fixed here; the tracker parameters must agree with them.
package tracker_pkg;

    localparam int PKG_CH_W  = 8;
    localparam int PKG_CNT_W = 19;
    localparam int COORD_W   = 10;
    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;

    typedef struct packed {
        logic [PKG_CH_W-1:0] r;
        logic [PKG_CH_W-1:0] g;
        logic [PKG_CH_W-1:0] b;
    } rgb_t;

    typedef struct packed {
        rgb_t lo;
        rgb_t hi;
    } thr_t;

    typedef struct packed {
        logic [COORD_W-1:0]   minH;
        logic [COORD_W-1:0]   maxH;
        logic [COORD_W-1:0]   minV;
        logic [COORD_W-1:0]   maxV;
        logic [PKG_CNT_W-1:0] count;
    } bbox_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REPORT = 2'd1,
        DONE   = 2'd2
    } rptState_t;

    // An empty box: min at the top of range, max at zero, so the first match overwrites both.
    localparam bbox_t BBOX_CLR = '{minH: '1, maxH: '0, minV: '1, maxV: '0, count: '0};

    function automatic logic inWindow(input rgb_t c, input thr_t t);
        return (c.r >= t.lo.r) && (c.r <= t.hi.r) &&
               (c.g >= t.lo.g) && (c.g <= t.hi.g) &&
               (c.b >= t.lo.b) && (c.b <= t.hi.b);
    endfunction

endpackage

// File: rtl/color_bbox_accum.sv
// One colour target: registered window match, bounding-box/count accumulation,
// and the frame-end snapshot that the report FSM reads.
module color_bbox_accum
    import tracker_pkg::*;
#(
    parameter int CNT_W = PKG_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pixVal,
    input  rgb_t               pix,
    input  thr_t               thr,
    input  logic               s1Val,
    input  logic [COORD_W-1:0] s1H,
    input  logic [COORD_W-1:0] s1V,
    input  logic               s1First,
    input  logic               s1Eof,
    output bbox_t              snap
);

    localparam logic [PKG_CNT_W-1:0] CNT_MAX = PKG_CNT_W'((64'd1 << CNT_W) - 64'd1);

    logic  matchQ;
    bbox_t live;
    bbox_t base;
    bbox_t upd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            matchQ <= 1'b0;
        end else if (pixVal) begin
            matchQ <= inWindow(pix, thr);
        end
    end

    // Pixel 0 starts from an empty box, which also discards a frame cut short by sof.
    always_comb begin
        base = s1First ? BBOX_CLR : live;
        upd  = base;
        if (matchQ) begin
            upd.minH  = (s1H < base.minH) ? s1H : base.minH;
            upd.maxH  = (s1H > base.maxH) ? s1H : base.maxH;
            upd.minV  = (s1V < base.minV) ? s1V : base.minV;
            upd.maxV  = (s1V > base.maxV) ? s1V : base.maxV;
            upd.count = (base.count == CNT_MAX) ? base.count : base.count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live <= BBOX_CLR;
            snap <= '0;
        end else if (s1Val) begin
            if (s1Eof) begin
                snap <= upd;
                live <= BBOX_CLR;
            end else begin
                live <= upd;
            end
        end
    end

endmodule

// File: rtl/multi_color_tracker.sv
// Raster-tracked colour classifier for N_TARGET windows; reports one centre per
// target after each frame end, followed by a frame-done pulse.
module multi_color_tracker
    import tracker_pkg::*;
#(
    parameter int H_RES    = H_RES_DEF,
    parameter int V_RES    = V_RES_DEF,
    parameter int N_TARGET = 2,
    parameter int CH_W     = PKG_CH_W,
    parameter int MIN_PIX  = 16,
    parameter int CNT_W    = PKG_CNT_W,
    localparam int TGT_W   = (N_TARGET > 1) ? $clog2(N_TARGET) : 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [3*CH_W-1:0]            i_RGB,
    input  logic                         i_pixelVAL,
    input  logic                         i_sof,
    input  logic [N_TARGET*3*CH_W-1:0]   i_thr_lo,
    input  logic [N_TARGET*3*CH_W-1:0]   i_thr_hi,
    output logic [9:0]                   o_pointH,
    output logic [9:0]                   o_pointV,
    output logic [TGT_W-1:0]             o_target,
    output logic                         o_found,
    output logic                         o_valid,
    output logic                         o_frame_done,
    output rptState_t                    o_dbgState
);

    logic [COORD_W-1:0] hCnt, vCnt, curH, curV;
    logic               isFirst, isEof;
    rgb_t               pix;

    assign pix     = i_RGB;
    assign curH    = i_sof ? '0 : hCnt;
    assign curV    = i_sof ? '0 : vCnt;
    assign isFirst = (curH == '0) && (curV == '0);
    assign isEof   = (curH == COORD_W'(H_RES - 1)) && (curV == COORD_W'(V_RES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hCnt <= '0;
            vCnt <= '0;
        end else if (i_pixelVAL) begin
            if (curH == COORD_W'(H_RES - 1)) begin
                hCnt <= '0;
                vCnt <= isEof ? '0 : curV + 1'b1;
            end else begin
                hCnt <= curH + 1'b1;
                vCnt <= curV;
            end
        end
    end

    logic               s1Val, s1First, s1Eof, snapNew;
    logic [COORD_W-1:0] s1H, s1V;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1Val   <= 1'b0;
            s1H     <= '0;
            s1V     <= '0;
            s1First <= 1'b0;
            s1Eof   <= 1'b0;
            snapNew <= 1'b0;
        end else begin
            s1Val   <= i_pixelVAL;
            snapNew <= s1Val && s1Eof;
            if (i_pixelVAL) begin
                s1H     <= curH;
                s1V     <= curV;
                s1First <= isFirst;
                s1Eof   <= isEof;
            end
        end
    end

    thr_t  thrIn  [N_TARGET];
    thr_t  thrLat [N_TARGET];
    thr_t  thrEff [N_TARGET];
    bbox_t snap   [N_TARGET];

    // Pixel 0 is classified with the thresholds being latched on that same cycle.
    for (genvar k = 0; k < N_TARGET; k++) begin : gTarget
        assign thrIn[k]  = {i_thr_lo[k*3*CH_W +: 3*CH_W], i_thr_hi[k*3*CH_W +: 3*CH_W]};
        assign thrEff[k] = (i_pixelVAL && isFirst) ? thrIn[k] : thrLat[k];

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                thrLat[k] <= '0;
            end else if (i_pixelVAL && isFirst) begin
                thrLat[k] <= thrIn[k];
            end
        end

        color_bbox_accum #(.CNT_W(CNT_W)) uAccum (
            .clk     (i_clk),
            .rst_n   (i_rst_n),
            .pixVal  (i_pixelVAL),
            .pix     (pix),
            .thr     (thrEff[k]),
            .s1Val   (s1Val),
            .s1H     (s1H),
            .s1V     (s1V),
            .s1First (s1First),
            .s1Eof   (s1Eof),
            .snap    (snap[k])
        );
    end

    rptState_t        state;
    logic [TGT_W-1:0] idx;
    bbox_t            snapSel;
    logic [COORD_W:0] sumH, sumV;
    logic             selFound;

    assign snapSel    = snap[idx];
    assign sumH       = {1'b0, snapSel.minH} + {1'b0, snapSel.maxH};
    assign sumV       = {1'b0, snapSel.minV} + {1'b0, snapSel.maxV};
    assign selFound   = snapSel.count >= PKG_CNT_W'(MIN_PIX);
    assign o_dbgState = state;

    // A fresh snapshot always restarts the report at target 0, whatever the state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            o_pointH     <= '0;
            o_pointV     <= '0;
            o_target     <= '0;
            o_found      <= 1'b0;
            o_valid      <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_valid      <= 1'b0;
            o_frame_done <= 1'b0;
            if (snapNew) begin
                state <= REPORT;
                idx   <= '0;
            end else begin
                case (state)
                    REPORT: begin
                        o_valid  <= 1'b1;
                        o_target <= idx;
                        o_found  <= selFound;
                        o_pointH <= selFound ? sumH[COORD_W:1] : '0;
                        o_pointV <= selFound ? sumV[COORD_W:1] : '0;
                        if (idx == TGT_W'(N_TARGET - 1)) begin
                            state <= DONE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    DONE: begin
                        o_frame_done <= 1'b1;
                        state        <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multi_color_tracker.sv
// Bench for multi_color_tracker on an 8x4 raster with two targets.
module tb_multi_color_tracker;

    localparam int H    = 8;
    localparam int V    = 4;
    localparam int N    = 2;
    localparam int MIN  = 4;
    localparam int NPIX = H * V;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [23:0] i_RGB = '0;
    logic        i_pixelVAL = 1'b0;
    logic        i_sof = 1'b0;
    logic [47:0] i_thr_lo = '0;
    logic [47:0] i_thr_hi = '0;
    logic [9:0]  o_pointH, o_pointV;
    logic        o_target, o_found, o_valid, o_frame_done;
    tracker_pkg::rptState_t o_dbgState;

    multi_color_tracker #(
        .H_RES(H), .V_RES(V), .N_TARGET(N), .MIN_PIX(MIN)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (i_rst_n),
        .i_RGB        (i_RGB),
        .i_pixelVAL   (i_pixelVAL),
        .i_sof        (i_sof),
        .i_thr_lo     (i_thr_lo),
        .i_thr_hi     (i_thr_hi),
        .o_pointH     (o_pointH),
        .o_pointV     (o_pointV),
        .o_target     (o_target),
        .o_found      (o_found),
        .o_valid      (o_valid),
        .o_frame_done (o_frame_done),
        .o_dbgState   (o_dbgState)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: every beat and every frame-done pulse, sampled mid-cycle
    logic [21:0] got_q[$];
    int doneCnt = 0, doneCyc = 0, v0Cyc = 0, lastValidCyc = 0;
    always @(negedge clk) begin
        if (o_valid) begin
            got_q.push_back({o_target, o_found, o_pointH, o_pointV});
            if (o_target == 1'b0) v0Cyc = cyc;
            lastValidCyc = cyc;
        end
        if (o_frame_done) begin
            doneCnt = doneCnt + 1;
            doneCyc = cyc;
        end
    end

    // scoreboard
    logic [21:0] exp_q[$];
    int nTests = 0, nFail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference model: scan the whole frame against the window rules
    logic [23:0] framePx [NPIX];
    logic [23:0] mLo [N];
    logic [23:0] mHi [N];

    function automatic logic [21:0] model(input int k);
        int cnt = 0, mnH = 1000, mxH = -1, mnV = 1000, mxV = -1;
        logic [23:0] p, lo, hi;
        bit m;
        lo = mLo[k];
        hi = mHi[k];
        for (int i = 0; i < NPIX; i++) begin
            p = framePx[i];
            m = 1'b1;
            for (int c = 0; c < 3; c++) begin
                if (p[c*8 +: 8] < lo[c*8 +: 8] || p[c*8 +: 8] > hi[c*8 +: 8]) m = 1'b0;
            end
            if (m) begin
                cnt++;
                if (i % H < mnH) mnH = i % H;
                if (i % H > mxH) mxH = i % H;
                if (i / H < mnV) mnV = i / H;
                if (i / H > mxV) mxV = i / H;
            end
        end
        if (cnt >= MIN) return {1'(k), 1'b1, 10'((mnH + mxH) / 2), 10'((mnV + mxV) / 2)};
        return {1'(k), 1'b0, 20'd0};
    endfunction

    // drivers
    task automatic set_thr(input int k, input logic [23:0] lo, input logic [23:0] hi);
        mLo[k] = lo;
        mHi[k] = hi;
        i_thr_lo[k*24 +: 24] = lo;
        i_thr_hi[k*24 +: 24] = hi;
    endtask

    task automatic build_box(input int h0, input int h1, input int v0, input int v1,
                             input logic [23:0] color);
        for (int i = 0; i < NPIX; i++)
            framePx[i] = (i % H >= h0 && i % H <= h1 && i / H >= v0 && i / H <= v1) ? color : 24'h0;
    endtask

    task automatic send_pix(input logic [23:0] p, input bit sof, input int gap,
                            input bit scramble, output int setCyc);
        @(negedge clk);
        if (scramble) begin
            i_thr_lo = 48'({$urandom(), $urandom()});
            i_thr_hi = 48'({$urandom(), $urandom()});
        end
        i_RGB = p;
        i_sof = sof;
        i_pixelVAL = 1'b1;
        setCyc = cyc;
        if (gap > 0) begin
            @(negedge clk);
            i_pixelVAL = 1'b0;
            i_sof = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    int endCyc = 0, gotBase = 0, prevDone = 0;

    task automatic run_frame(input int gapMode, input bit sofFirst, input bit scramble);
        int g, sc, t;
        gotBase = got_q.size();
        prevDone = doneCnt;
        for (int i = 0; i < NPIX; i++) begin
            g = (gapMode < 0) ? $urandom_range(2, 0) : gapMode;
            send_pix(framePx[i], sofFirst && (i == 0), g, scramble && (i == 1), sc);
            if (i == NPIX - 1) endCyc = sc + 1;
        end
        @(negedge clk);
        i_pixelVAL = 1'b0;
        i_sof = 1'b0;
        t = 0;
        while (doneCnt == prevDone && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
    endtask

    task automatic check_frame(input string name);
        logic [21:0] e;
        chk({name, "_beats"}, 64'(got_q.size() - gotBase), 64'd2);
        for (int b = 0; b < 2; b++) begin
            e = exp_q.pop_front();
            chk($sformatf("%s_beat%0d", name, b), 64'(got_q[gotBase + b]), 64'(e));
        end
        chk({name, "_done_cnt"}, 64'(doneCnt), 64'(prevDone + 1));
        chk({name, "_latency"}, 64'(v0Cyc - endCyc), 64'd3);
        chk({name, "_done_after_beat1"}, 64'(doneCyc - lastValidCyc), 64'd1);
    endtask

    typedef struct {
        int h0, h1, v0, v1;
        logic [23:0] color;
        int gap;
        bit sof;
        bit expFound;
        int expH, expV;
    } vec_t;

    vec_t vecs [6];
    logic [23:0] pal [4];
    int cnt0, sc;
    logic [23:0] lo, hi;

    initial begin
        vecs[0] = '{2, 4, 1, 2, 24'hFF0000, 0, 1'b1, 1'b1, 3, 1};
        vecs[1] = '{2, 4, 1, 1, 24'hFF0000, 0, 1'b0, 1'b0, 0, 0};
        vecs[2] = '{6, 7, 2, 3, 24'hC83200, 0, 1'b1, 1'b1, 6, 2};
        vecs[3] = '{6, 7, 2, 3, 24'hC70000, 1, 1'b0, 1'b0, 0, 0};
        vecs[4] = '{2, 4, 1, 2, 24'hFF0000, 2, 1'b1, 1'b1, 3, 1};
        vecs[5] = '{0, 7, 3, 3, 24'hFF0000, 0, 1'b0, 1'b1, 3, 3};

        // reset with random inputs: every output must sit at zero
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            i_RGB = 24'($urandom());
            i_pixelVAL = 1'($urandom_range(1, 0));
            i_sof = 1'($urandom_range(1, 0));
            i_thr_lo = 48'({$urandom(), $urandom()});
            i_thr_hi = 48'({$urandom(), $urandom()});
            #1;
            chk("reset_outputs", 64'({o_pointH, o_pointV, o_target, o_found, o_valid,
                                      o_frame_done, o_dbgState}), 64'd0);
        end
        @(negedge clk);
        i_pixelVAL = 1'b0;
        i_sof = 1'b0;
        i_rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_no_beats", 64'(got_q.size()), 64'd0);
        chk("idle_no_done", 64'(doneCnt), 64'd0);

        // table-driven frames; target 1 has an empty window (lo > hi)
        set_thr(0, 24'hC80000, 24'hFF3232);
        set_thr(1, 24'hFFFFFF, 24'h000000);
        for (int v = 0; v < 6; v++) begin
            build_box(vecs[v].h0, vecs[v].h1, vecs[v].v0, vecs[v].v1, vecs[v].color);
            run_frame(vecs[v].gap, vecs[v].sof, 1'b0);
            exp_q.push_back({1'b0, vecs[v].expFound, 10'(vecs[v].expH), 10'(vecs[v].expV)});
            exp_q.push_back(model(1));
            check_frame($sformatf("vec%0d", v));
        end

        // sof at pixel index 10 drops the partial frame and starts a new one
        build_box(0, 7, 0, 3, 24'hFF0000);
        gotBase = got_q.size();
        prevDone = doneCnt;
        for (int i = 0; i < 10; i++) send_pix(framePx[i], i == 0, 0, 1'b0, sc);
        build_box(2, 4, 1, 2, 24'hFF0000);
        run_frame(0, 1'b1, 1'b0);
        exp_q.push_back({1'b0, 1'b1, 10'd3, 10'd1});
        exp_q.push_back({1'b1, 1'b0, 20'd0});
        check_frame("sof_restart");

        // reset during the second report beat, then a clean frame at 1-in-3 pacing
        prevDone = doneCnt;
        for (int i = 0; i < NPIX; i++) send_pix(framePx[i], 1'b0, 2, 1'b0, sc);
        cnt0 = 0;
        while (!(o_valid && o_target == 1'b1) && cnt0 < 100) begin
            @(negedge clk);
            cnt0++;
        end
        chk("reached_beat1", 64'(o_valid && o_target), 64'd1);
        #2 i_rst_n = 1'b0;
        #1;
        chk("reset_mid_report", 64'({o_pointH, o_pointV, o_target, o_found, o_valid,
                                      o_frame_done, o_dbgState}), 64'd0);
        repeat (10) @(negedge clk);
        chk("no_done_after_abort", 64'(doneCnt), 64'(prevDone));
        i_rst_n = 1'b1;
        run_frame(2, 1'b0, 1'b0);
        exp_q.push_back({1'b0, 1'b1, 10'd3, 10'd1});
        exp_q.push_back({1'b1, 1'b0, 20'd0});
        check_frame("after_reset");

        // random windows and pixels, thresholds scrambled mid-frame, random gaps
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < N; k++) begin
                for (int c = 0; c < 3; c++) begin
                    lo[c*8 +: 8] = 8'($urandom_range(150, 0));
                    hi[c*8 +: 8] = 8'(lo[c*8 +: 8] + $urandom_range(105, 0));
                    pal[k][c*8 +: 8] = 8'((lo[c*8 +: 8] + hi[c*8 +: 8]) / 2);
                end
                set_thr(k, lo, hi);
            end
            pal[2] = 24'($urandom());
            pal[3] = 24'h000000;
            for (int i = 0; i < NPIX; i++) framePx[i] = pal[$urandom_range(3, 0)];
            run_frame(-1, f[0], 1'b1);
            exp_q.push_back(model(0));
            exp_q.push_back(model(1));
            check_frame($sformatf("rand%0d", f));
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/multi_color_tracker.md
Name: multi_color_tracker

Overview:
- Parametrised successor to the single-target Tracker.
- Consumes the raster pixel stream (RGB plus pixel-valid, 640x480 default) from the camera/VGA path.
- Classifies every pixel against N_TARGET programmable colour windows and accumulates a per-target bounding box and pixel count.
- At frame end, reports one centre point per target, sequentially, on a valid-qualified output bus.

Parameters:
- H_RES, 640: active pixels per line.
- V_RES, 480: active lines per frame.
- N_TARGET, 2: number of colour targets tracked (1..8).
- CH_W, 8: bits per colour channel.
- MIN_PIX, 16: minimum matched-pixel count for a target to count as found.
- CNT_W, 19: pixel-count width (saturating).

Ports:
- i_clk  in  1  system clock (25 MHz).
- i_rst_n  in  1  asynchronous, active-low reset.
- i_RGB  in  3*CH_W  pixel as {R,G,B}.
- i_pixelVAL  in  1  pixel valid; one pixel accepted per high cycle.
- i_sof  in  1  start of frame; qualified by i_pixelVAL; marks the pixel at (0,0).
- i_thr_lo  in  N_TARGET*3*CH_W  per-target lower bounds; target k occupies slice k.
- i_thr_hi  in  N_TARGET*3*CH_W  per-target upper bounds.
- o_pointH  out  10  reported centre, horizontal.
- o_pointV  out  10  reported centre, vertical.
- o_target  out  $clog2(N_TARGET) (min 1)  target index of the current report.
- o_found  out  1  target met MIN_PIX this frame.
- o_valid  out  1  report beat valid.
- o_frame_done  out  1  single-cycle pulse after the last report beat.

Behaviour:
- Interface: one clock, i_clk. Reset i_rst_n is asynchronous, active-low.
- Reset values:
  - All outputs 0.
  - Raster counters h=v=0.
  - Accumulators cleared.
  - Report FSM in IDLE.
- Raster tracking:
  - h increments on each accepted pixel; wraps at H_RES-1 to 0, then v increments.
  - The pixel at (H_RES-1, V_RES-1) is the frame-end pixel; both counters then return to 0.
- i_sof with i_pixelVAL forces that pixel to (0,0).
  - If this occurs mid-frame, discard the partial accumulation with no report.
  - This pixel is accumulated as pixel 0 of the new frame.
- Threshold latching:
  - Thresholds are latched when the pixel at (0,0) is accepted.
  - Changes to i_thr_lo/i_thr_hi mid-frame have no effect until the next frame.
- Match rule: pixel matches target k iff lo<=c<=hi on all three channels (inclusive, unsigned).
  - A pixel may match several targets.
  - lo>hi on any channel means the target never matches.
- Pipeline stage 1 registers the per-target match vector plus h, v and a frame-end flag.
- Stage 2 updates each matched target's accumulators:
  - minH, maxH, minV, maxV.
  - count, saturating at 2^CNT_W-1.
- Frame end:
  - Copy the accumulators into snapshot registers and clear the live accumulators in the same cycle.
  - Pixels of the next frame may arrive back-to-back with no bubble.
- Report FSM: IDLE -> REPORT(k=0..N_TARGET-1) -> DONE -> IDLE.
  - In REPORT, o_valid=1 for exactly one cycle per target, in ascending k.
  - o_found = (count>=MIN_PIX).
  - If found: o_pointH=(minH+maxH)>>1 and o_pointV=(minV+maxV)>>1, summed at 11 bits.
  - If not found: o_pointH=o_pointV=0.
  - DONE asserts o_frame_done for one cycle, then returns to IDLE.
- Latency: first o_valid asserts on the 3rd rising edge after the edge that accepted the frame-end pixel.
- A new snapshot arriving while in REPORT/DONE overwrites the snapshot and restarts the report at k=0. This is unreachable at legal frame sizes.
- Gaps in i_pixelVAL: counters and accumulators hold. Results are independent of the gap pattern.
- Reset asserted mid-frame or mid-report clears everything immediately. No o_frame_done is emitted for the aborted frame.
- Outputs other than o_valid/o_frame_done hold their last value between beats.

Decomposition:
- Shared package tracker_pkg holds:
  - rgb_t (packed R,G,B, CH_W each).
  - thr_t {lo,hi}.
  - bbox_t {minH,maxH,minV,maxV,count}.
  - Report FSM enum.
  - Default H_RES/V_RES constants.
- One natural sub-module, color_bbox_accum, instantiated N_TARGET times. It contains:
  - The match compare.
  - The bounding-box/count update.
  - Snapshot registers.
- The top level owns the raster counters, threshold latch and report FSM.

Test Plan:
- Reset: assert i_rst_n=0 with random inputs -> all outputs 0. Without pixels, o_valid never asserts.
- Bench params H_RES=8, V_RES=4, N_TARGET=2, MIN_PIX=4. Stimulus:
  - Target0 window lo={200,0,0}, hi={255,50,50}.
  - Red {255,0,0} at H2..4, V1..2 (6 px); all other pixels black.
  - Response: beat0 shows target=0, found=1, H=3, V=1. Beat1 shows target=1, found=0, H=0, V=0. o_frame_done follows 1 cycle later.
- Only 3 matching pixels -> target0 found=0 and point 0,0.
- Inclusive edges: pixel {200,50,0} matches. Pixel {199,0,0} does not.
- i_sof asserted at pixel index 10 -> no report. Exactly 32 pixels later, a report for the new frame appears with correct box.
- Stream with 1 valid every 3 cycles (the existing tb pattern), plus reset asserted during REPORT beat1 -> outputs 0 immediately. The next full frame gives the same report as the back-to-back case.
